// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem request in flight and hands words to decode.
// Optional FETCH_MISALIGN_CHK_EN: a misaligned redirect halts fetch and sets sticky misalign_err.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [INST_W-1:0] inst_data,
  output logic              misalign_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends combinationally on ready, and redirect overrides any transfer.
`ifdef FETCH_MISALIGN_CHK_EN
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_DROP, S_HOLD, S_HALT} state_t;
`else
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] buf_q, buf_d;
  logic              run_q;
  logic [ADDR_W-1:0] tgt;
  logic              fire;

`ifdef FETCH_MISALIGN_CHK_EN
  logic err_q, err_d;
  assign tgt          = redirect_addr;
  assign misalign_err = err_q;
`else
  assign tgt          = redirect_addr & ~ADDR_W'(3);
  assign misalign_err = 1'b0;
`endif

  // run_q holds requests off until the first clock edge after reset release.
  assign imem_req_valid = run_q && (state_q == S_REQ);
  assign imem_addr      = pc_q;
  assign inst_valid     = (state_q == S_HOLD);
  assign inst_pc        = pc_q;
  assign inst_data      = buf_q;
  assign fire           = imem_req_valid && imem_req_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
`ifdef FETCH_MISALIGN_CHK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          state_d = fire ? S_DROP : S_REQ;
        end else if (fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          state_d = imem_resp_valid ? S_REQ : S_DROP;
        end else if (imem_resp_valid) begin
          buf_d   = imem_resp_data;
          state_d = S_HOLD;
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_d = tgt;
        if (imem_resp_valid) state_d = S_REQ;
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + ADDR_W'(4);
          state_d = S_REQ;
        end
      end
      default: state_d = state_q;
    endcase
`ifdef FETCH_MISALIGN_CHK_EN
    // A misaligned redirect from any live state parks the unit until reset.
    if (redirect_valid && (state_q != S_HALT) && (redirect_addr[1:0] != 2'b00)) begin
      pc_d    = redirect_addr;
      err_d   = 1'b1;
      state_d = S_HALT;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      run_q   <= 1'b1;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: imem responder, driver sequence, and a scoreboard monitor
// that checks every instruction decode accepts against an expected {pc,data} queue.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        misalign_err;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];

  logic        pending   = 1'b0;
  logic [31:0] pend_addr = '0;
  logic        resp_hold = 1'b0;

  fetch_unit #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .misalign_err   (misalign_err)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0000_5A5A;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    exp_q.push_back({pc, mem(pc)});
  endtask

  task automatic redirect(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
  endtask

  // imem model: one response, one cycle after the accepting edge, unless resp_hold is set
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      imem_resp_valid = 1'b0;
      if (pending && !resp_hold) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem(pend_addr);
        pending         = 1'b0;
      end
      if (!rst && imem_req_valid && imem_req_ready) begin
        pending   = 1'b1;
        pend_addr = imem_addr;
      end
    end
  end

  // scoreboard monitor: an accepted instruction is valid & ready without a redirect
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst && inst_valid && inst_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", {inst_pc, inst_data}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_inst", {inst_pc, inst_data}, e);
        end
      end
    end
  end

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    tick(3);
    chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
    chk("rst_inst_valid", 64'(inst_valid), 64'h0);
    chk("rst_misalign", 64'(misalign_err), 64'h0);
    chk("rst_addr", 64'(imem_addr), 64'h0);

    // sequential fetch 0,4,8 at one instruction per 3 cycles
    rst = 1'b0;
    push(32'h0); push(32'h4); push(32'h8);
    tick(1);
    chk("first_req_valid", 64'(imem_req_valid), 64'h1);
    chk("first_req_addr", 64'(imem_addr), 64'h0);
    tick(2);
    chk("hold0_valid", 64'(inst_valid), 64'h1);
    chk("hold0_pc", 64'(inst_pc), 64'h0);
    tick(3);
    chk("hold4_pc", 64'(inst_pc), 64'h4);
    tick(3);
    chk("hold8_pc", 64'(inst_pc), 64'h8);

    // decode stall: held word stays put, no new request
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("stall_valid", 64'(inst_valid), 64'h1);
      chk("stall_word", {inst_pc, inst_data}, {32'h8, mem(32'h8)});
      chk("stall_no_req", 64'(imem_req_valid), 64'h0);
    end
    inst_ready = 1'b1;
    tick(1);
    chk("after_stall_addr", 64'(imem_addr), 64'hC);

    // redirect in WAIT with no response -> DROP, stale response discarded
    resp_hold = 1'b1;
    tick(1);
    chk("wait_no_req", 64'(imem_req_valid), 64'h0);
    redirect(32'h100);
    tick(1);
    redirect_valid = 1'b0;
    chk("drop_no_req", 64'(imem_req_valid), 64'h0);
    chk("drop_pc", 64'(imem_addr), 64'h100);
    tick(2);
    chk("drop_stays", 64'(imem_req_valid), 64'h0);
    resp_hold = 1'b0;
    push(32'h100);
    tick(1);
    chk("drop_exit_req", {31'h0, imem_req_valid, imem_addr}, {31'h0, 1'b1, 32'h100});
    tick(2);
    chk("hold100_pc", 64'(inst_pc), 64'h100);

    // redirect in HOLD with inst_ready=1: held word dropped, no pc+4
    tick(3);
    chk("hold104_pc", 64'(inst_pc), 64'h104);
    redirect(32'h40);
    tick(1);
    redirect_valid = 1'b0;
    chk("hold_redir_inst_valid", 64'(inst_valid), 64'h0);
    chk("hold_redir_addr", 64'(imem_addr), 64'h40);
    push(32'h40);
    tick(2);
    chk("hold40_pc", 64'(inst_pc), 64'h40);

    // redirect on the accepting edge in REQ, then pc wrap at the top of memory
    tick(1);
    chk("req44_addr", 64'(imem_addr), 64'h44);
    redirect(32'hFFFF_FFFC);
    tick(1);
    redirect_valid = 1'b0;
    chk("fire_redir_drop", 64'(imem_req_valid), 64'h0);
    chk("fire_redir_pc", 64'(imem_addr), 64'hFFFF_FFFC);
    push(32'hFFFF_FFFC);
    tick(1);
    chk("top_req", {31'h0, imem_req_valid, imem_addr}, {31'h0, 1'b1, 32'hFFFF_FFFC});
    tick(2);
    chk("hold_top_pc", 64'(inst_pc), 64'hFFFF_FFFC);
    tick(1);
    chk("wrap_addr", 64'(imem_addr), 64'h0);

    // redirect in REQ while imem is not ready: address moves while valid
    imem_req_ready = 1'b0;
    tick(1);
    chk("req_stall", {31'h0, imem_req_valid, imem_addr}, {31'h0, 1'b1, 32'h0});
    redirect(32'h200);
    tick(1);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    chk("req_redir_addr", {31'h0, imem_req_valid, imem_addr}, {31'h0, 1'b1, 32'h200});
    push(32'h200);
    tick(2);
    chk("hold200_pc", 64'(inst_pc), 64'h200);
    tick(1);

    // misaligned redirect
    imem_req_ready = 1'b0;
    redirect(32'h102);
    tick(1);
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    chk("mis_err", 64'(misalign_err), 64'h1);
    chk("mis_no_req", 64'(imem_req_valid), 64'h0);
    imem_req_ready = 1'b1;
    tick(4);
    chk("halt_no_req", 64'(imem_req_valid), 64'h0);
    chk("halt_no_inst", 64'(inst_valid), 64'h0);
    chk("halt_err_sticky", 64'(misalign_err), 64'h1);
`else
    chk("mis_addr", 64'(imem_addr), 64'h100);
    chk("mis_err", 64'(misalign_err), 64'h0);
    chk("mis_req", 64'(imem_req_valid), 64'h1);
    imem_req_ready = 1'b1;
    push(32'h100);
    tick(2);
    chk("hold_mis_pc", 64'(inst_pc), 64'h100);
    tick(1);
    // park in WAIT with the response withheld, then reset
    resp_hold = 1'b1;
    tick(1);
    chk("pre_rst_wait", 64'(imem_req_valid), 64'h0);
`endif

    // reset mid-operation; any stale response after release must be ignored
    rst = 1'b1;
    #1;
    chk("midrst_req", 64'(imem_req_valid), 64'h0);
    chk("midrst_inst", 64'(inst_valid), 64'h0);
    chk("midrst_addr", 64'(imem_addr), 64'h0);
    chk("midrst_err", 64'(misalign_err), 64'h0);
    tick(1);
    rst       = 1'b0;
    resp_hold = 1'b0;
    push(32'h0);
    tick(1);
    chk("post_rst_req", {31'h0, imem_req_valid, imem_addr}, {31'h0, 1'b1, 32'h0});
    chk("post_rst_no_inst", 64'(inst_valid), 64'h0);
    tick(2);
    chk("post_rst_hold_pc", {31'h0, inst_valid, inst_pc}, {31'h0, 1'b1, 32'h0});
    imem_req_ready = 1'b0;
    tick(3);
    chk("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
